// File: rtl/fft512_pkg.sv
// Shared definitions for the 512-point FFT pipeline.
//   DATA_W  : signed component width of real/imag samples
//   FFT_LEN : transform length
//   sdf_state_t : radix-2 SDF butterfly controller states
package fft512_pkg;

    localparam int DATA_W  = 24;
    localparam int FFT_LEN = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BF    = 2'd2,
        DRAIN = 2'd3
    } sdf_state_t;

endpackage

// File: rtl/r2_sdf_butterfly_cplx_addsub.sv
// cplx_addsub: combinational complex sum and difference.
// Results are formed at W+1 bits and wrapped to W bits; there is no
// scaling and no saturation.
//   a_r, a_i     : in  W  signed operand a
//   b_r, b_i     : in  W  signed operand b
//   sum_r, sum_i : out W  wrapped a+b
//   dif_r, dif_i : out W  wrapped a-b
import fft512_pkg::*;

module cplx_addsub #(
    parameter int W = DATA_W
) (
    input  logic signed [W-1:0] a_r,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_r,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_r,
    output logic signed [W-1:0] sum_i,
    output logic signed [W-1:0] dif_r,
    output logic signed [W-1:0] dif_i
);

    logic signed [W:0] sr, si, dr, di;

    always_comb begin
        sr = {a_r[W-1], a_r} + {b_r[W-1], b_r};
        si = {a_i[W-1], a_i} + {b_i[W-1], b_i};
        dr = {a_r[W-1], a_r} - {b_r[W-1], b_r};
        di = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    end

    assign sum_r = sr[W-1:0];
    assign sum_i = si[W-1:0];
    assign dif_r = dr[W-1:0];
    assign dif_i = di[W-1:0];

endmodule

// File: rtl/r2_sdf_butterfly.sv
// r2_sdf_butterfly: radix-2 single-path delay-feedback butterfly controller.
// Writes first-half samples into an external N-deep delay line, combines
// them with the second half (sums out, differences fed back), and emits the
// differences during the next frame's fill or an autonomous drain.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake (ready low only while draining)
//   din_r, din_i      : input sample
//   dly_r, dly_i      : oldest delay-line sample
//   to_dly_r/_i       : delay-line input (combinational)
//   dly_shift         : delay-line shift enable (combinational)
//   out_valid, dout_* : registered output sample
import fft512_pkg::*;

module r2_sdf_butterfly #(
    parameter int N = 128,
    parameter int W = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] din_r,
    input  logic signed [W-1:0] din_i,
    input  logic signed [W-1:0] dly_r,
    input  logic signed [W-1:0] dly_i,
    output logic signed [W-1:0] to_dly_r,
    output logic signed [W-1:0] to_dly_i,
    output logic                dly_shift,
    output logic                out_valid,
    output logic signed [W-1:0] dout_r,
    output logic signed [W-1:0] dout_i
);

    localparam int CW = $clog2(N);

    sdf_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic pend, pend_n, cnt_inc, emit, accept, last, drain_start;
    logic signed [W-1:0] nxt_r, nxt_i;
    logic signed [W-1:0] sum_r, sum_i, dif_r, dif_i;

    cplx_addsub #(.W(W)) u_addsub (
        .a_r  (dly_r),
        .a_i  (dly_i),
        .b_r  (din_r),
        .b_i  (din_i),
        .sum_r(sum_r),
        .sum_i(sum_i),
        .dif_r(dif_r),
        .dif_i(dif_i)
    );

    assign last = (cnt == CW'(N - 1));

    // Differences are pending but no next frame arrives at its first slot:
    // this cycle already acts as the first drain cycle, so the difference
    // stream follows the sums without a bubble and ready is low N cycles.
    assign drain_start = (state == FILL) && pend && (cnt == '0) && !in_valid;
    assign in_ready    = !((state == DRAIN) || drain_start);
    assign accept      = in_valid && in_ready;

    always_comb begin
        state_n   = state;
        pend_n    = pend;
        cnt_inc   = 1'b0;
        dly_shift = 1'b0;
        to_dly_r  = '0;
        to_dly_i  = '0;
        emit      = 1'b0;
        nxt_r     = '0;
        nxt_i     = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    to_dly_r  = din_r;
                    to_dly_i  = din_i;
                    dly_shift = 1'b1;
                    cnt_inc   = 1'b1;
                    state_n   = FILL;
                end
            end
            FILL: begin
                if (drain_start) begin
                    dly_shift = 1'b1;
                    emit      = 1'b1;
                    nxt_r     = dly_r;
                    nxt_i     = dly_i;
                    cnt_inc   = 1'b1;
                    state_n   = DRAIN;
                end else begin
                    to_dly_r  = din_r;
                    to_dly_i  = din_i;
                    dly_shift = accept;
                    if (accept) begin
                        cnt_inc = 1'b1;
                        if (pend) begin
                            emit  = 1'b1;
                            nxt_r = dly_r;
                            nxt_i = dly_i;
                        end
                        if (last) begin
                            state_n = BF;
                            pend_n  = 1'b0;
                        end
                    end
                end
            end
            BF: begin
                to_dly_r  = dif_r;
                to_dly_i  = dif_i;
                dly_shift = accept;
                if (accept) begin
                    emit    = 1'b1;
                    nxt_r   = sum_r;
                    nxt_i   = sum_i;
                    cnt_inc = 1'b1;
                    if (last) begin
                        state_n = FILL;
                        pend_n  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                dly_shift = 1'b1;
                emit      = 1'b1;
                nxt_r     = dly_r;
                nxt_i     = dly_i;
                cnt_inc   = 1'b1;
                if (last) begin
                    state_n = IDLE;
                    pend_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            out_valid <= emit;
            if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (emit) begin
                dout_r <= nxt_r;
                dout_i <= nxt_i;
            end
        end
    end

endmodule
